// File: rtl/des_pkg.sv
// Shared types and helpers for the serial sequence-detector controller.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } des_ctrl_state_t;

  localparam logic [3:0] DES_RST_PAT = 4'b1011;

  // Match count must represent 0..word_w inclusive.
  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

  function automatic int unsigned pos_width(input int unsigned word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/des_ctrl_ser.sv
// Word shift register and bit counter; presents one bit per shift, MSB first.
module des_ctrl_ser #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              det_in,
  output logic [CNT_W-1:0]  bit_idx,
  output logic              last_bit
);

  logic [WORD_W-1:0] sh;

  // bit_idx is the index of the bit currently on det_in; it reaches WORD_W after the last shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh      <= '0;
      det_in  <= 1'b0;
      bit_idx <= '0;
    end else if (load) begin
      det_in  <= data[WORD_W-1];
      sh      <= data << 1;
      bit_idx <= '0;
    end else if (shift) begin
      det_in  <= sh[WORD_W-1];
      sh      <= sh << 1;
      bit_idx <= bit_idx + CNT_W'(1);
    end
  end

  assign last_bit = (bit_idx == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/des_ctrl.sv
// Sequences words into the serial detector and reports per-word match count and first position.
module des_ctrl
  import des_pkg::*;
#(
  parameter int unsigned        WORD_W  = 8,
  parameter int unsigned        LENGTH  = 4,
  parameter logic [LENGTH-1:0]  RST_PAT = LENGTH'(DES_RST_PAT),
  parameter int unsigned        CNT_W   = cnt_width(WORD_W),
  parameter int unsigned        POS_W   = pos_width(WORD_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [LENGTH-1:0] cfg_pattern,
  input  logic              cfg_clr_each,
  output logic              cfg_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              det_in,
  output logic              det_en,
  output logic              det_clr,
  output logic [LENGTH-1:0] det_pattern,
  input  logic              det_out,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [CNT_W-1:0]  r_count,
  output logic [POS_W-1:0]  r_pos
);

  des_ctrl_state_t   state, next_state;
  logic              clr_each, prev_en;
  logic              ser_load, ser_shift;
  logic [CNT_W-1:0]  bit_idx;
  logic              last_bit;

  logic              s_ready_d, cfg_ready_d, det_en_d, det_clr_d, r_valid_d, clr_each_d;
  logic [LENGTH-1:0] pat_d;
  logic [CNT_W-1:0]  count_d;
  logic [POS_W-1:0]  pos_d;

  des_ctrl_ser #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ser_load),
    .shift    (ser_shift),
    .data     (s_data),
    .det_in   (det_in),
    .bit_idx  (bit_idx),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!cfg_we && s_valid && s_ready) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DRAIN;
      DRAIN:   next_state = REPORT;
      REPORT:  if (r_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_ready_d   = s_ready;
    cfg_ready_d = (next_state == IDLE);
    det_en_d    = 1'b0;
    det_clr_d   = 1'b0;
    r_valid_d   = (next_state == REPORT);
    pat_d       = det_pattern;
    clr_each_d  = clr_each;
    count_d     = r_count;
    pos_d       = r_pos;
    ser_load    = 1'b0;
    ser_shift   = 1'b0;
    case (state)
      IDLE: begin
        // A config write wins and blocks word intake for the following clear cycle.
        if (cfg_we) begin
          pat_d      = cfg_pattern;
          clr_each_d = cfg_clr_each;
          det_clr_d  = 1'b1;
          s_ready_d  = 1'b0;
        end else if (s_valid && s_ready) begin
          ser_load  = 1'b1;
          count_d   = '0;
          pos_d     = '1;
          det_clr_d = clr_each;
          det_en_d  = 1'b1;
          s_ready_d = 1'b0;
        end else begin
          s_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        ser_shift = 1'b1;
        det_en_d  = !last_bit;
      end
      REPORT: if (r_ready) s_ready_d = 1'b1;
      default: ;
    endcase
    // A match seen now belongs to the bit presented last cycle.
    if (det_out && prev_en) begin
      if (r_count != CNT_W'(WORD_W)) count_d = r_count + CNT_W'(1);
      if (r_count == '0) pos_d = POS_W'(bit_idx - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ready     <= 1'b1;
      cfg_ready   <= 1'b1;
      det_en      <= 1'b0;
      det_clr     <= 1'b0;
      r_valid     <= 1'b0;
      r_count     <= '0;
      r_pos       <= '1;
      det_pattern <= RST_PAT;
      clr_each    <= 1'b1;
      prev_en     <= 1'b0;
    end else begin
      s_ready     <= s_ready_d;
      cfg_ready   <= cfg_ready_d;
      det_en      <= det_en_d;
      det_clr     <= det_clr_d;
      r_valid     <= r_valid_d;
      r_count     <= count_d;
      r_pos       <= pos_d;
      det_pattern <= pat_d;
      clr_each    <= clr_each_d;
      prev_en     <= det_en;
    end
  end

endmodule

// File: tb/tb_des_ctrl.sv
// Bench for des_ctrl with a behavioural serial detector and a result scoreboard.
module tb_des_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned LENGTH = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned POS_W  = 3;
  localparam int          NONE   = 7;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_we, cfg_clr_each, cfg_ready;
  logic [LENGTH-1:0] cfg_pattern;
  logic              s_valid, s_ready;
  logic [WORD_W-1:0] s_data;
  logic              det_in, det_en, det_clr, det_out;
  logic [LENGTH-1:0] det_pattern;
  logic              r_valid, r_ready;
  logic [CNT_W-1:0]  r_count;
  logic [POS_W-1:0]  r_pos;

  typedef struct {
    int cnt;
    int pos;
  } exp_t;
  exp_t exp_q[$];

  int n_run  = 0;
  int n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  des_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_we       (cfg_we),
    .cfg_pattern  (cfg_pattern),
    .cfg_clr_each (cfg_clr_each),
    .cfg_ready    (cfg_ready),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .det_in       (det_in),
    .det_en       (det_en),
    .det_clr      (det_clr),
    .det_pattern  (det_pattern),
    .det_out      (det_out),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_count      (r_count),
    .r_pos        (r_pos)
  );

  // Detector model: shift history, clear on det_clr (a bit consumed alongside the clear is kept).
  logic [LENGTH-1:0] hist, nh;
  always_comb nh = det_clr ? {{(LENGTH-1){1'b0}}, det_in} : {hist[LENGTH-2:0], det_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist    <= '0;
      det_out <= 1'b0;
    end else begin
      if (det_en)       hist <= nh;
      else if (det_clr) hist <= '0;
      det_out <= det_en && (nh == det_pattern);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input int c, input int p);
    exp_t e;
    e.cnt = c;
    e.pos = p;
    exp_q.push_back(e);
  endtask

  // Result monitor: pops one expectation per accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("r_count", 32'(r_count), 32'(e.cnt));
          check("r_pos", 32'(r_pos), 32'(e.pos));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_word(input logic [WORD_W-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 100);
    check("s_ready_wait", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!r_valid && l < 100);
    check("r_valid_wait", 32'(r_valid), 1);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d);
    int l;
    start_word(d);
    wait_result(l);
    check("latency", 32'(l), WORD_W + 2);
  endtask

  task automatic do_cfg(input logic [LENGTH-1:0] p, input logic c);
    @(posedge clk); #1;
    cfg_we       = 1'b1;
    cfg_pattern  = p;
    cfg_clr_each = c;
    @(negedge clk);
    check("cfg_ready_idle", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    check("det_pattern_cfg", 32'(det_pattern), 32'(p));
    check("det_clr_pulse", 32'(det_clr), 1);
    check("s_ready_after_cfg", 32'(s_ready), 0);
    @(negedge clk);
    check("det_clr_end", 32'(det_clr), 0);
    check("s_ready_back", 32'(s_ready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 1);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
    check({tag, "_det_en"}, 32'(det_en), 0);
    check({tag, "_det_in"}, 32'(det_in), 0);
    check({tag, "_det_clr"}, 32'(det_clr), 0);
    check({tag, "_r_valid"}, 32'(r_valid), 0);
    check({tag, "_r_count"}, 32'(r_count), 0);
    check({tag, "_r_pos"}, 32'(r_pos), NONE);
    check({tag, "_det_pattern"}, 32'(det_pattern), 32'hB);
  endtask

  initial begin
    rstn         = 1'b0;
    cfg_we       = 1'b0;
    cfg_pattern  = '0;
    cfg_clr_each = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    r_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Reset pattern 1011, clear every word.
    expect_result(2, 3);
    send_word(8'b1011_1011);
    expect_result(2, 3);
    send_word(8'b1011_0110);

    // Backpressure in REPORT.
    expect_result(2, 3);
    start_word(8'hBB);
    r_ready = 1'b0;
    wait_result(lat);
    check("bp_latency", 32'(lat), WORD_W + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_r_valid", 32'(r_valid), 1);
      check("bp_r_count", 32'(r_count), 2);
      check("bp_r_pos", 32'(r_pos), 3);
      check("bp_s_ready", 32'(s_ready), 0);
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_r_valid_drop", 32'(r_valid), 0);
    check("bp_idle_s_ready", 32'(s_ready), 1);

    // Config write while shifting is dropped.
    expect_result(2, 3);
    start_word(8'hBB);
    @(posedge clk); #1;
    cfg_we       = 1'b1;
    cfg_pattern  = 4'b0110;
    cfg_clr_each = 1'b1;
    @(negedge clk);
    check("cfg_ready_shift", 32'(cfg_ready), 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("det_pattern_kept", 32'(det_pattern), 32'hB);
    wait_result(lat);

    // Config write in IDLE takes effect.
    do_cfg(4'b0110, 1'b1);
    expect_result(2, 3);
    send_word(8'h66);

    // Asynchronous reset mid-word discards it.
    start_word(8'hBB);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    expect_result(2, 3);
    send_word(8'hBB);

    // History across word boundaries.
    do_cfg(4'b1011, 1'b0);
    expect_result(0, NONE);
    send_word(8'h05);
    expect_result(1, 0);
    send_word(8'h80);
    do_cfg(4'b1011, 1'b1);
    expect_result(0, NONE);
    send_word(8'h05);
    expect_result(0, NONE);
    send_word(8'h80);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/des_ctrl.md
# des_ctrl

Controller that sequences the serial sequence-detector datapath. It accepts parallel words on a valid/ready stream and shifts them MSB-first into the detector's one-bit input. It counts the detector's match pulses per word and returns a count plus first-match position on a valid/ready result stream. It also owns the detector's programmable pattern register and its history-clear control.

## Interface
- WORD_W, 8, bits per input word
- LENGTH, 4, pattern length in bits
- RST_PAT, 4'b1011, pattern value loaded at reset
- CNT_W, $clog2(WORD_W+1), width of match count
- POS_W, $clog2(WORD_W), width of match position

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cfg_we  in  1  pattern/mode write strobe
- cfg_pattern  in  LENGTH  new pattern
- cfg_clr_each  in  1  new mode: 1 = clear detector history at the start of every word
- cfg_ready  out  1  write accepted this cycle when cfg_we=1
- s_valid  in  1  input word valid
- s_ready  out  1  controller can accept a word
- s_data  in  WORD_W  input word
- det_in  out  1  serial bit to detector
- det_en  out  1  detector consumes det_in this cycle
- det_clr  out  1  one-cycle detector history clear
- det_pattern  out  LENGTH  registered pattern to detector
- det_out  in  1  detector match; registered, valid the cycle after the completing bit
- r_valid  out  1  result valid
- r_ready  in  1  result consumer ready
- r_count  out  CNT_W  matches in the word
- r_pos  out  POS_W  bit index (0 = first bit shifted) completing the first match; all ones if r_count=0

## Operation
- States: IDLE, SHIFT, DRAIN, REPORT.
- IDLE:
  - s_ready=1, cfg_ready=1.
  - cfg_we has priority over s_valid in the same cycle. On a write: load pattern and mode, pulse det_clr next cycle, and keep s_ready=0 that cycle.
  - On s_valid&&s_ready: capture word, clear count, bit counter=0, r_pos=all ones. If mode clr_each=1, pulse det_clr in the same cycle. Go to SHIFT.
- SHIFT:
  - det_en=1, det_in=word[WORD_W-1-bitcnt], bitcnt++ each cycle.
  - After WORD_W cycles, go to DRAIN.
- DRAIN: det_en=0; one cycle to collect the match for the last bit. Go to REPORT.
- Match collection:
  - prev_en is det_en delayed one cycle.
  - In any cycle with det_out && prev_en: increment count, saturating at WORD_W.
  - If that is the first match, r_pos = bitcnt-1 (the bit presented the previous cycle).
  - det_out with prev_en=0 is ignored. This covers the first SHIFT cycle and stale history.
- REPORT: r_valid=1 and r_count/r_pos held stable until r_ready; then go to IDLE.
- cfg_ready=0 outside IDLE; a cfg_we there is dropped (no effect).
- clr_each=0: detector history spans word boundaries. A match completed by bit 0 of a word counts in that word.

## Timing
- Reset values:
  - State=IDLE.
  - s_ready=1, cfg_ready=1 immediately after reset.
  - det_en=0, det_in=0, det_clr=0, r_valid=0, r_count=0, r_pos=all ones.
  - det_pattern=RST_PAT, clr_each=1.
- Latency and throughput:
  - Handshake at cycle 0.
  - det_en high cycles 1..WORD_W; DRAIN at WORD_W+1; r_valid at WORD_W+2.
  - Minimum word period WORD_W+3 cycles (r_ready held high).
- All outputs registered. det_clr is exactly one cycle wide.
- rstn low at any point, including mid-SHIFT or REPORT: asynchronous return to reset values. The partial word is discarded and no result is produced.

## Structure
- Shared package des_pkg: state enum des_ctrl_state_t, RST_PAT default constant, CNT_W/POS_W helper functions.
- Sub-module des_ctrl_ser: word shift register plus bit counter, producing det_in and a last_bit flag.
- The FSM, match counter and config registers stay in des_ctrl.

## Test plan
- Pattern 1011, clr_each=1, word 8'b1011_1011 -> r_count=2, r_pos=3, r_valid at cycle 10 after handshake.
- Overlap: word 8'b1011_0110 -> r_count=2 (matches at bits 3 and 6), r_pos=3.
- Cross-word history: clr_each=0, word 8'h05 then 8'h80 -> results count=0, then count=1 with pos=0. Repeat with clr_each=1 -> second result count=0, r_pos=8'hFF-equivalent (all ones).
- Backpressure: hold r_ready=0 for 5 cycles in REPORT -> r_valid, r_count, r_pos stable; s_ready=0; then one-cycle handshake returns to IDLE.
- Config: cfg_we with pattern 0110 during SHIFT -> cfg_ready=0 and det_pattern unchanged. The same write in IDLE -> det_pattern=0110, one det_clr pulse, and a subsequent word 8'h66 gives count=2.
- Reset mid-SHIFT (after 3 bits): all outputs at reset values the same cycle; no r_valid. The next word is processed normally.
